cpu_ctrl: RTL

//  Instruction sequencer for the 8-bit CPU; the master side of the ALU interface.
//  - Fetches 1- or 2-byte instructions from ROM and decodes the opcode.
//  - Drives the ALU opcode and operands, writes the ALU result back to ACC/REG and latches flags.
//  - Owns PC, ACC, FLAGS, a small register file and the RAM port.

---
 rtl/cpu_ctrl_pkg.sv | 29 ++
 rtl/cpu_ctrl_regfile.sv | 35 +++
 rtl/cpu_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 8-bit CPU sequencer: opcodes, FSM states and decode helpers.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDO = 4'h1, OP_LDA = 4'h2, OP_LDR = 4'h3,
    OP_PRE = 4'h4, OP_STO = 4'h5, OP_ADD = 4'h6, OP_SHL = 4'h7,
    OP_SHR = 4'h8, OP_SAR = 4'h9, OP_INV = 4'hA, OP_AND = 4'hB,
    OP_OR  = 4'hC, OP_XOR = 4'hD, OP_JMP = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPFETCH, S_OPLOAD, S_MEM, S_EXEC, S_HALT
  } state_e;

  // Two-byte instructions carry an address/target in the byte after the opcode.
  function automatic logic is_long_op(opcode_e op);
    return op inside {OP_LDO, OP_LDA, OP_STO, OP_JMP};
  endfunction

  function automatic logic is_mem_load(opcode_e op);
    return op inside {OP_LDO, OP_LDA};
  endfunction

  function automatic logic writes_acc(opcode_e op);
    return op inside {OP_LDO, OP_LDA, OP_PRE, OP_ADD, OP_SHL, OP_SHR,
                      OP_SAR, OP_INV, OP_AND, OP_OR, OP_XOR};
  endfunction

endpackage

// File: rtl/cpu_ctrl_regfile.sv
// General-purpose register file: REG_NUM x 8 bits, one async read port, one sync write port.
module cpu_ctrl_regfile #(
  parameter int REG_NUM = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] raddr,
  output logic [7:0] rdata,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata
);

  localparam int AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  logic [7:0] regs [REG_NUM];

  // The instruction field is 4 bits wide; smaller files alias modulo their depth.
  function automatic logic [AW-1:0] wrap(input logic [3:0] idx);
    return AW'(32'(idx) % REG_NUM);
  endfunction

  assign rdata = regs[wrap(raddr)];

  // NOTE: software expects every register to read as zero after reset, so the
  // whole array is cleared here rather than left as an unreset memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wrap(waddr)] <= wdata;
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction sequencer for the 8-bit CPU: fetch/decode FSM, ALU master, ACC/FLAGS/PC and RAM port.
module cpu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [7:0] PC_RST  = 8'h00,
  parameter int         REG_NUM = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] ram_addr,
  input  logic [7:0] ram_rdata,
  output logic [7:0] ram_wdata,
  output logic       ram_we,
  output logic [3:0] alu_ins,
  output logic [7:0] alu_opnd,
  output logic [7:0] alu_acc,
  input  logic [7:0] alu_res,
  input  logic [3:0] alu_flags,
  output logic [7:0] pc,
  output logic [7:0] acc,
  output logic [3:0] flags,
  output logic       halted
);

  state_e     state, state_next;
  logic [7:0] ir, opnd;
  opcode_e    op, fetched_op;
  logic [7:0] rf_rdata;
  logic       rf_we;

  assign op         = opcode_e'(ir[7:4]);
  assign fetched_op = opcode_e'(rom_data[7:4]);
  assign ram_wdata  = acc;
  assign alu_acc    = acc;
  assign halted     = (state == S_HALT);

  cpu_ctrl_regfile #(.REG_NUM(REG_NUM)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .raddr (ir[3:0]),
    .rdata (rf_rdata),
    .we    (rf_we),
    .waddr (ir[3:0]),
    .wdata (alu_res)
  );

  // NOTE: all architectural state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= PC_RST;
      acc   <= '0;
      flags <= '0;
      ir    <= '0;
      opnd  <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_DECODE: begin
          ir <= rom_data;
          pc <= pc + 8'd1;
        end
        S_OPLOAD: begin
          opnd <= rom_data;
          pc   <= pc + 8'd1;
        end
        S_EXEC: begin
          if (writes_acc(op)) begin
            acc   <= alu_res;
            flags <= alu_flags;
          end
          if (op == OP_JMP) pc <= opnd;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH:   state_next = S_DECODE;
      S_DECODE: begin
        if (fetched_op == OP_HLT)     state_next = S_HALT;
        else if (is_long_op(fetched_op)) state_next = S_OPFETCH;
        else                          state_next = S_EXEC;
      end
      S_OPFETCH: state_next = S_OPLOAD;
      S_OPLOAD:  state_next = is_mem_load(op) ? S_MEM : S_EXEC;
      S_MEM:     state_next = S_EXEC;
      S_EXEC:    state_next = S_FETCH;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_FETCH;
    endcase
  end

  // NOTE: every output gets a default before the case, so no state can leave
  // one unassigned and infer a latch.
  always_comb begin
    rom_addr = pc;
    ram_addr = '0;
    ram_we   = 1'b0;
    alu_ins  = OP_NOP;
    alu_opnd = '0;
    rf_we    = 1'b0;
    case (state)
      S_MEM: begin
        ram_addr = opnd;
        if (op == OP_LDO) rom_addr = opnd;
      end
      S_EXEC: begin
        ram_addr = opnd;
        alu_ins  = op;
        case (op)
          OP_LDO:  alu_opnd = rom_data;
          OP_LDA:  alu_opnd = ram_rdata;
          OP_JMP:  alu_opnd = opnd;
          default: alu_opnd = rf_rdata;
        endcase
        // Reset wins over a store in flight: the strobe drops in the same cycle.
        ram_we = (op == OP_STO) && !rst;
        rf_we  = (op == OP_LDR);
      end
      default: ;
    endcase
  end

endmodule
